// File: rtl/fft_acc_pkg.sv
// Shared constants and helpers for the FFT accelerator sample loader.
// Holds the memory-port geometry, the default frame size and the
// {real, imag} word packing used when writing samples.
package fft_acc_pkg;

  localparam int MEM_ADDR_W     = 16;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_BE_W       = 4;
  localparam int LOG2_N_DEFAULT = 10;

  // Complex sample word as the FFT engine expects it: real in the upper half.
  function automatic logic [MEM_DATA_W-1:0] pack_sample(input logic [15:0] re,
                                                        input logic [15:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_acc_sample_loader_bitrev.sv
// Bit-order mirror used to form the bit-reversed write address.
// Ports: value (WIDTH bits in), reversed (WIDTH bits out, bit i = value[WIDTH-1-i]).
// Purely combinational.
module fft_acc_bitrev #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] reversed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_mirror
    assign reversed[i] = value[WIDTH-1-i];
  end

endmodule

// File: rtl/fft_acc_sample_loader.sv
// Sample loader: packs 16-bit real samples into complex words and writes them
// bit-reversed into a ping-pong pair of N-point banks for the in-place FFT.
// Ports: clk/reset_n/enable/clear control; snk_* sample stream (valid/ready);
// mem_* write port (one strobe per accepted sample, registered, no wait-states);
// frame_valid/frame_base/frame_release hand-off to the FFT engine;
// release_err sticky misuse flag; fill_level = samples in the bank filling.
module fft_acc_sample_loader
  import fft_acc_pkg::*;
#(
  parameter int                    LOG2_N    = LOG2_N_DEFAULT,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  snk_valid,
  input  logic [15:0]           snk_data,
  output logic                  snk_ready,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [MEM_BE_W-1:0]   mem_byteenable,
  output logic [MEM_DATA_W-1:0] mem_writedata,
  output logic                  mem_clken,
  output logic                  frame_valid,
  output logic [MEM_ADDR_W-1:0] frame_base,
  input  logic                  frame_release,
  output logic                  release_err,
  output logic [LOG2_N:0]       fill_level
);

  localparam logic [MEM_ADDR_W-1:0] BANK_SIZE = MEM_ADDR_W'(1 << LOG2_N);
  localparam logic [LOG2_N:0]       CNT_LAST  = (LOG2_N+1)'((1 << LOG2_N) - 1);

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        bank_full;
  logic [1:0]        bank_full_next;
  logic [LOG2_N:0]   cnt;
  // Completion is deferred one cycle so the final write lands before the
  // bank is advertised to the FFT engine.
  logic              full_pend;
  logic              full_pend_bank;

  logic              accept;
  logic              last;
  logic              release_ok;
  logic [LOG2_N-1:0] cnt_rev;
  logic [MEM_ADDR_W-1:0] wr_addr;

  fft_acc_bitrev #(
    .WIDTH (LOG2_N)
  ) u_bitrev (
    .value    (cnt[LOG2_N-1:0]),
    .reversed (cnt_rev)
  );

  assign snk_ready      = enable & ~bank_full[wr_bank];
  assign accept         = snk_valid & snk_ready;
  assign last           = (cnt == CNT_LAST);
  assign frame_valid    = bank_full[rd_bank];
  assign frame_base     = BASE_ADDR + (rd_bank ? BANK_SIZE : '0);
  assign release_ok     = frame_release & frame_valid;
  assign wr_addr        = BASE_ADDR + (wr_bank ? BANK_SIZE : '0) + MEM_ADDR_W'(cnt_rev);
  assign mem_byteenable = '1;
  assign fill_level     = cnt;

  // Release and deferred completion always target different banks (a bank
  // being completed is never full yet), so both updates apply together.
  always_comb begin
    bank_full_next = bank_full;
    if (release_ok) bank_full_next[rd_bank] = 1'b0;
    if (full_pend)  bank_full_next[full_pend_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      bank_full      <= 2'b00;
      cnt            <= '0;
      full_pend      <= 1'b0;
      full_pend_bank <= 1'b0;
      release_err    <= 1'b0;
      mem_clken      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else if (clear) begin
      // Clear beats accept and release; the write stage is flushed too.
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      bank_full      <= 2'b00;
      cnt            <= '0;
      full_pend      <= 1'b0;
      full_pend_bank <= 1'b0;
      release_err    <= 1'b0;
      mem_clken      <= 1'b1;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      mem_clken      <= 1'b1;
      mem_chipselect <= accept;
      mem_write      <= accept;
      if (accept) begin
        mem_address   <= wr_addr;
        mem_writedata <= pack_sample(snk_data, 16'h0000);
        cnt           <= last ? '0 : cnt + 1'b1;
        if (last) wr_bank <= ~wr_bank;
      end
      full_pend      <= accept & last;
      full_pend_bank <= wr_bank;
      bank_full      <= bank_full_next;
      if (release_ok) rd_bank <= ~rd_bank;
      if (frame_release & ~frame_valid) release_err <= 1'b1;
    end
  end

endmodule
